fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_next_pc.sv | 42 ++++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, next-PC selector encoding and target helper for the fetch stage.
package fetch_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_BRANCH,
        PC_JUMP,
        PC_HOLD
    } pc_sel_e;

    // Word offset is scaled to bytes, so the low two bits of the target stay zero.
    function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] base,
                                                      input logic [15:0]     offset);
        return base + {{(XLEN-18){offset[15]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: stall hold, jump, taken branch or sequential.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] ifid_pc_plus4_i,
    input  logic            stall_i,
    input  logic            jump_en_i,
    input  logic [25:0]     jump_index_i,
    input  logic            branch_taken_i,
    input  logic [15:0]     branch_offset_i,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] next_pc_o
);

    pc_sel_e sel;

    assign pc_plus4_o = pc_i + XLEN'(4);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel = PC_SEQ;
        if (stall_i) begin
            sel = PC_HOLD;
        end else if (jump_en_i) begin
            sel = PC_JUMP;
        end else if (branch_taken_i) begin
            sel = PC_BRANCH;
        end
    end

    always_comb begin
        next_pc_o = pc_plus4_o;
        unique case (sel)
            PC_HOLD:   next_pc_o = pc_i;
            PC_JUMP:   next_pc_o = {ifid_pc_plus4_i[XLEN-1:XLEN-4], jump_index_i, 2'b00};
            PC_BRANCH: next_pc_o = branch_target(ifid_pc_plus4_i, branch_offset_i);
            PC_SEQ:    next_pc_o = pc_plus4_o;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and delivered-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [15:0]     branch_offset,
    input  logic            jump_en,
    input  logic [25:0]     jump_index,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic            ifid_valid,
    output logic [XLEN-1:0] fetch_count
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] count_q, count_d;
    logic [XLEN-1:0] seq_pc;

    fetch_next_pc u_next_pc (
        .pc_i            (pc_q),
        .ifid_pc_plus4_i (pc_plus4_q),
        .stall_i         (stall),
        .jump_en_i       (jump_en),
        .jump_index_i    (jump_index),
        .branch_taken_i  (branch_taken),
        .branch_offset_i (branch_offset),
        .pc_plus4_o      (seq_pc),
        .next_pc_o       (pc_d)
    );

    // Flush overrides stall for IF/ID; the slot still records the PC+4 it would have carried.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        count_d    = count_q;
        if (flush) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = seq_pc;
            valid_d    = 1'b0;
        end else if (!stall) begin
            instr_d    = imem_instr;
            pc_plus4_d = seq_pc;
            valid_d    = 1'b1;
            count_d    = count_q + XLEN'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc_plus4 = pc_plus4_q;
    assign ifid_valid    = valid_q;
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, short hand sequence, random run vs model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = '0;
    logic        jump_en = 1'b0;
    logic [25:0] jump_index = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump_en       (jump_en),
        .jump_index    (jump_index),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .fetch_count   (fetch_count)
    );

    // Instruction memory contents: address-dependent and never zero, so a nop is distinguishable.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[31:2], 2'b01} ^ 32'hC3A5_0000;
    endfunction

    assign imem_instr = imem_word(imem_addr);

    typedef struct {
        logic        rst, stl, fl, br;
        logic [15:0] off;
        logic        jmp;
        logic [25:0] idx;
        logic [31:0] e_addr, e_pp4;
        logic        e_valid;
        logic [31:0] e_count, e_instr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, stl, fl, br, input logic [15:0] off,
                               input logic jmp, input logic [25:0] idx,
                               input logic [31:0] e_addr, e_pp4, input logic e_valid,
                               input logic [31:0] e_count, e_instr);
        vec_t r;
        r.rst = rst; r.stl = stl; r.fl = fl; r.br = br; r.off = off;
        r.jmp = jmp; r.idx = idx; r.e_addr = e_addr; r.e_pp4 = e_pp4;
        r.e_valid = e_valid; r.e_count = e_count; r.e_instr = e_instr;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_addr, e_pp4,
                             input logic e_valid, input logic [31:0] e_count, e_instr);
        check({tag, " imem_addr"}, imem_addr, e_addr);
        check({tag, " ifid_pc_plus4"}, ifid_pc_plus4, e_pp4);
        check({tag, " ifid_valid"}, {31'b0, ifid_valid}, {31'b0, e_valid});
        check({tag, " fetch_count"}, fetch_count, e_count);
        check({tag, " ifid_instr"}, ifid_instr, e_instr);
    endtask

    task automatic drive(input logic rst, stl, fl, br, input logic [15:0] off,
                         input logic jmp, input logic [25:0] idx);
        reset = rst; stall = stl; flush = fl; branch_taken = br;
        branch_offset = off; jump_en = jmp; jump_index = idx;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state, advanced once per clock from the fetch rules.
    logic [31:0] m_pc, m_instr, m_pp4, m_count;
    logic        m_valid;

    task automatic model_step(input logic rst, stl, fl, br, input logic [15:0] off,
                              input logic jmp, input logic [25:0] idx);
        logic [31:0] cur;
        logic [31:0] id_pp4;
        cur    = m_pc;
        id_pp4 = m_pp4;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
        end else begin
            if (fl) begin
                m_instr = 32'h0; m_valid = 1'b0; m_pp4 = cur + 32'd4;
            end else if (!stl) begin
                m_instr = imem_word(cur); m_valid = 1'b1; m_pp4 = cur + 32'd4;
                m_count = m_count + 32'd1;
            end
            if (!stl) begin
                if (jmp)
                    m_pc = (id_pp4 & 32'hF000_0000) | (32'(idx) * 32'd4);
                else if (br)
                    m_pc = id_pp4 + 32'(int'($signed(off)) * 4);
                else
                    m_pc = cur + 32'd4;
            end
        end
    endtask

    initial begin
        // rst stl fl br off jmp idx | addr pp4 valid count instr
        tbl.push_back(v(1,0,0,0,16'h0,0,26'h0, 32'h00, 32'h00, 0,  0, 32'h0));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h04, 32'h04, 1,  1, imem_word(32'h00)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h08, 32'h08, 1,  2, imem_word(32'h04)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h0C, 32'h0C, 1,  3, imem_word(32'h08)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h10, 32'h10, 1,  4, imem_word(32'h0C)));
        // Stall three cycles at PC 0x10; redirects during the stall are ignored.
        tbl.push_back(v(0,1,0,0,16'h0,0,26'h0, 32'h10, 32'h10, 1,  4, imem_word(32'h0C)));
        tbl.push_back(v(0,1,0,1,16'h7,1,26'h9, 32'h10, 32'h10, 1,  4, imem_word(32'h0C)));
        tbl.push_back(v(0,1,0,1,16'h3,0,26'h0, 32'h10, 32'h10, 1,  4, imem_word(32'h0C)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h14, 32'h14, 1,  5, imem_word(32'h10)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h18, 32'h18, 1,  6, imem_word(32'h14)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h1C, 32'h1C, 1,  7, imem_word(32'h18)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h20, 32'h20, 1,  8, imem_word(32'h1C)));
        // Flush with stall at PC 0x20.
        tbl.push_back(v(0,1,1,0,16'h0,0,26'h0, 32'h20, 32'h24, 0,  8, 32'h0));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h24, 32'h24, 1,  9, imem_word(32'h20)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h28, 32'h28, 1, 10, imem_word(32'h24)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h2C, 32'h2C, 1, 11, imem_word(32'h28)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h30, 32'h30, 1, 12, imem_word(32'h2C)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h34, 32'h34, 1, 13, imem_word(32'h30)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h38, 32'h38, 1, 14, imem_word(32'h34)));
        // Branch in ID with pc_plus4 0x38, offset 1: delay slot 0x38 loads, target 0x3C.
        tbl.push_back(v(0,0,0,1,16'h1,0,26'h0, 32'h3C, 32'h3C, 1, 15, imem_word(32'h38)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h40, 32'h40, 1, 16, imem_word(32'h3C)));
        // Jump with index 6 beats a simultaneous taken branch.
        tbl.push_back(v(0,0,0,1,16'h5,1,26'h6, 32'h18, 32'h44, 1, 17, imem_word(32'h40)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h1C, 32'h1C, 1, 18, imem_word(32'h18)));
        // Backward branches: 0x1C - 12 = 0x10, then 0x20 - 36 = 0xFFFF_FFFC.
        tbl.push_back(v(0,0,0,1,16'hFFFD,0,26'h0, 32'h10, 32'h20, 1, 19, imem_word(32'h1C)));
        tbl.push_back(v(0,0,0,1,16'hFFF7,0,26'h0, 32'hFFFF_FFFC, 32'h14, 1, 20, imem_word(32'h10)));
        // Sequential wrap past the top of the address space.
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h00, 32'h00, 1, 21, imem_word(32'hFFFF_FFFC)));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h04, 32'h04, 1, 22, imem_word(32'h00)));
        // Reset mid-run wins over stall, flush and jump.
        tbl.push_back(v(1,1,1,0,16'h0,1,26'h3, 32'h00, 32'h00, 0,  0, 32'h0));
        tbl.push_back(v(0,0,0,0,16'h0,0,26'h0, 32'h04, 32'h04, 1,  1, imem_word(32'h00)));

        step();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].fl, tbl[i].br, tbl[i].off, tbl[i].jmp, tbl[i].idx);
            step();
            check_all($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_pp4, tbl[i].e_valid,
                      tbl[i].e_count, tbl[i].e_instr);
        end

        // Flush without stall: slot squashed and not counted, PC still advances.
        drive(0,0,1,0,16'h0,0,26'h0);
        step();
        check_all("flush_only", 32'h08, 32'h08, 1'b0, 32'd1, 32'h0);
        drive(0,0,0,0,16'h0,0,26'h0);
        step();
        check_all("after_flush", 32'h0C, 32'h0C, 1'b1, 32'd2, imem_word(32'h08));

        // Randomized run against the reference model, starting from reset.
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_stl, r_fl, r_br, r_jmp;
            logic [15:0] r_off;
            logic [25:0] r_idx;
            r_rst = (i == 0) || ($urandom_range(0, 49) == 0);
            r_stl = ($urandom_range(0, 3) == 0);
            r_fl  = ($urandom_range(0, 7) == 0);
            r_br  = ($urandom_range(0, 3) == 0);
            r_jmp = ($urandom_range(0, 7) == 0);
            r_off = 16'($urandom);
            r_idx = 26'($urandom);
            drive(r_rst, r_stl, r_fl, r_br, r_off, r_jmp, r_idx);
            step();
            model_step(r_rst, r_stl, r_fl, r_br, r_off, r_jmp, r_idx);
            check_all($sformatf("rand%0d", i), m_pc, m_pp4, m_valid, m_count, m_instr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
